// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 encodings for the execute stage
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;

    localparam logic [3:0] RNONE    = 4'hF;

    function automatic logic is_exception(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - add/sub/and/xor ALU with zero, sign and overflow flags
import y86_pkg::*;

module alu_core #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fn,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = b + a;
                of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            // subtraction is b - a, matching Y86 subq rA, rB
            ALU_SUB: begin
                result = b - a;
                of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[WIDTH-1];

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - Y86-64 execute stage: E register, ALU operand select, CC and condition
import y86_pkg::*;

module execute_pipe #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_stall,
    input  logic             E_bubble,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [WIDTH-1:0] D_valA,
    input  logic [WIDTH-1:0] D_valB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [3:0]       D_dstE,
    input  logic [3:0]       D_dstM,
    input  logic [3:0]       D_stat,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_stat,
    output logic [WIDTH-1:0] e_valE,
    output logic [WIDTH-1:0] e_valA,
    output logic [3:0]       e_dstE,
    output logic [3:0]       E_dstM,
    output logic             e_Cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valA, E_valB, E_valC;
    logic [3:0]       E_dstE;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_fn;
    logic             alu_zf, alu_sf, alu_of;
    logic             set_cc;

    always_ff @(posedge clk) begin
        if (reset || E_bubble) begin
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_stat  <= S_AOK;
            E_valA  <= '0;
            E_valB  <= '0;
            E_valC  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
        end else if (!E_stall) begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_stat  <= D_stat;
            E_valA  <= D_valA;
            E_valB  <= D_valB;
            E_valC  <= D_valC;
            E_dstE  <= D_dstE;
            E_dstM  <= D_dstM;
        end
    end

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:                alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = E_valC;
            I_CALL, I_PUSHQ:                alu_a = '0 - STEP;
            I_RET, I_POPQ:                  alu_a = STEP;
            default:                        alu_a = '0;
        endcase
    end

    assign alu_b  = (E_icode == I_RRMOVQ || E_icode == I_IRMOVQ) ? '0 : E_valB;
    assign alu_fn = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (e_valE),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Exceptions further down the pipe must not let younger OPq change the flags
    assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR)
                    && !is_exception(m_stat) && !is_exception(W_stat);

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (set_cc) begin
            cc_zf <= alu_zf;
            cc_sf <= alu_sf;
            cc_of <= alu_of;
        end
    end

    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            C_YES:   e_Cnd = 1'b1;
            C_LE:    e_Cnd = (cc_sf ^ cc_of) | cc_zf;
            C_L:     e_Cnd = cc_sf ^ cc_of;
            C_E:     e_Cnd = cc_zf;
            C_NE:    e_Cnd = ~cc_zf;
            C_GE:    e_Cnd = ~(cc_sf ^ cc_of);
            C_G:     e_Cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;
    assign e_valA = E_valA;

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the datapath word width in bits (multiple of 8, >= 16).
REQ-002 SHALL have parameter STACK_STEP, default WIDTH/8, meaning the stack-pointer adjustment in bytes for call/push/ret/pop.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports E_stall and E_bubble, input, 1 bit each: pipeline-register hold and insert-bubble controls.
REQ-006 SHALL have ports D_icode and D_ifun, input, 4 bits each: decoded instruction code and function.
REQ-007 SHALL have ports D_valA, D_valB and D_valC, input, WIDTH bits each: operands and constant.
REQ-008 SHALL have ports D_dstE, D_dstM and D_stat, input, 4 bits each: destination register IDs and status.
REQ-009 SHALL have ports m_stat and W_stat, input, 4 bits each: downstream status used to block CC updates.
REQ-010 SHALL have ports E_icode and E_stat, output, 4 bits each: registered instruction code and status.
REQ-011 SHALL have ports e_valE and e_valA, output, WIDTH bits each: ALU result and passed-through valA.
REQ-012 SHALL have ports e_dstE and E_dstM, output, 4 bits each: effective ALU destination and registered memory destination.
REQ-013 SHALL have port e_Cnd, output, 1 bit: condition result for cmovXX/jXX.
REQ-014 SHALL have ports cc_zf, cc_sf and cc_of, output, 1 bit each: the condition-code register.

Function
REQ-015 SHALL, on each rising edge, update the E register as follows, in priority order: reset loads a bubble; E_bubble loads a bubble (takes priority over E_stall); E_stall holds; otherwise the D_* inputs load.
REQ-016 SHALL define a bubble as icode=1 (nop), ifun=0, stat=1 (AOK), dstE=dstM=0xF, and all data fields 0.
REQ-017 SHALL select aluA = valA for icode 2/6; valC for icode 3/4/5; -STACK_STEP for icode 8/A; +STACK_STEP for icode 9/B; 0 otherwise.
REQ-018 SHALL select aluB = 0 for icode 2/3; valB for all other icodes.
REQ-019 SHALL, for icode 6, use the ALU function given by ifun (0 add, 1 sub computing aluB-aluA, 2 and, 3 xor); for every other icode the ALU SHALL add.
REQ-020 SHALL, for icode 6 with an ifun greater than 3, produce e_valE=0 and leave the CC register unchanged.
REQ-021 SHALL truncate all arithmetic modulo 2^WIDTH.
REQ-022 SHALL compute the new flags as: ZF = (result==0); SF = result[WIDTH-1]; OF = signed overflow for add/sub and 0 for and/xor.
REQ-023 SHALL latch the new flags on the next edge only when E_icode==6, the ifun is valid, and neither m_stat nor W_stat is 2/3/4 (HLT/ADR/INS); the CC register SHALL hold otherwise.
REQ-024 SHALL compute e_Cnd combinationally from the CC register and E_ifun: 0 always; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF; any other ifun gives 0.
REQ-025 SHALL drive e_dstE = 0xF when E_icode==2 and e_Cnd==0; otherwise e_dstE SHALL equal E_dstE.
REQ-026 SHALL make all e_* outputs combinational from the E register and CC, giving zero-cycle latency after the E register; the CC update SHALL be visible one cycle after the OPq occupies E.

Reset
REQ-027 SHALL, while reset is asserted at a rising edge, load a bubble into the E register and set CC to ZF=1, SF=0, OF=0, overriding E_stall and E_bubble.
REQ-028 SHALL, after a reset asserted mid-stream, discard the in-flight instruction and perform no CC update for it.

Structure
REQ-029 SHALL take the icode/ifun encodings, stat codes (AOK=1, HLT=2, ADR=3, INS=4), RNONE=0xF and the ALU function codes from the shared package y86_pkg.
REQ-030 SHALL contain one sub-module, alu_core (parameterised by WIDTH, producing result, zf, sf and of); the pipeline register, CC register and condition logic SHALL stay in execute_pipe.

Verification
REQ-031 SHALL cover: OPq sub with valA=5, valB=10 -> e_valE=5, and one cycle later ZF=0, SF=0, OF=0.
REQ-032 SHALL cover: WIDTH=64 OPq add with valA=1, valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0x8000_0000_0000_0000, and next cycle SF=1, OF=1, ZF=0.
REQ-033 SHALL cover: with CC S=1, O=0, cmovl dstE=3 -> e_Cnd=1 and e_dstE=3; cmovg -> e_Cnd=0 and e_dstE=0xF.
REQ-034 SHALL cover: OPq xor with valA=valB=7 while m_stat=3 -> e_valE=0 and CC unchanged; the same instruction with m_stat=1 -> ZF=1.
REQ-035 SHALL cover: E_stall held 3 cycles -> E outputs constant; E_stall and E_bubble together -> E_icode=1, e_dstE=0xF.
REQ-036 SHALL cover: call with valB=0x100 under WIDTH=64 -> e_valE=0xF8; under WIDTH=32 the same (STACK_STEP=4 gives 0xFC).
